// File: rtl/mod_ex_div_unit_pkg.sv
// mod_ex_div_unit_pkg: shared types and constants for the iterative EX-stage divider
package mod_ex_div_unit_pkg;
    localparam int DIV_XLEN = 32;
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;
    localparam logic [DIV_XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [DIV_XLEN-1:0] SIGNED_MIN = {1'b1, {(DIV_XLEN-1){1'b0}}};
endpackage

// File: rtl/mod_div_step.sv
// mod_div_step: combinational restoring shift/subtract retiring BITS_PER_CYCLE quotient bits
module mod_div_step #(
    parameter int XLEN = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    // shift the next dividend bit into the partial remainder, subtract when it fits
    always_comb begin
        rem_o = rem_i;
        quo_o = quo_i;
        trial = '0;
        diff  = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            trial = {rem_o, quo_o[XLEN-1]};
            diff  = trial - {1'b0, div_i};
            rem_o = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
            quo_o = {quo_o[XLEN-2:0], ~diff[XLEN]};
        end
    end
endmodule

// File: rtl/mod_ex_div_unit.sv
// mod_ex_div_unit: iterative RV32M DIV/DIVU/REM/REMU unit that stalls the front end while busy
module mod_ex_div_unit
    import mod_ex_div_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            ex2mem_stall_i,
    input  logic            flush_i,
    output logic            ex_stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    div_state_e      state_q, state_n;
    div_op_e         op_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q, result_q;
    logic [XLEN-1:0] step_rem, step_quo, a_abs, b_abs, special_res, final_res;
    logic            neg_q_q, neg_r_q, valid_q;
    logic            is_signed, is_rem, a_neg, b_neg, div_zero, overflow, special, accept;

    // decode the op presented in ID/EX and spot the RISC-V special cases up front
    always_comb begin
        is_signed   = op_i == DIV || op_i == REM;
        is_rem      = op_i == REM || op_i == REMU;
        a_neg       = is_signed && dividend_i[XLEN-1];
        b_neg       = is_signed && divisor_i[XLEN-1];
        a_abs       = a_neg ? -dividend_i : dividend_i;
        b_abs       = b_neg ? -divisor_i : divisor_i;
        div_zero    = divisor_i == '0;
        overflow    = is_signed && dividend_i == XLEN'(SIGNED_MIN) && divisor_i == '1;
        special     = div_zero || overflow;
        special_res = div_zero ? (is_rem ? dividend_i : XLEN'(DIV_BY_ZERO_Q))
                               : (is_rem ? '0 : XLEN'(SIGNED_MIN));
        accept      = state_q == IDLE && start_i && !flush_i;
        final_res   = (op_q == REM || op_q == REMU) ? (neg_r_q ? -step_rem : step_rem)
                                                    : (neg_q_q ? -step_quo : step_quo);
    end

    mod_div_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // next state; flush wins over everything, DONE waits only on the EX/MEM freeze
    always_comb begin
        state_n = flush_i                ? IDLE
                : accept                 ? (special ? DONE : BUSY)
                : state_q == BUSY        ? (cnt_q == '0 ? DONE : BUSY)
                : state_q == DONE        ? (ex2mem_stall_i ? DONE : IDLE)
                :                          state_q;
        ex_stall_req_o = rst_ni && !flush_i && (accept || state_q == BUSY);
    end

    // state, iteration counter and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            valid_q <= state_n == DONE;
            if (accept) begin
                op_q    <= div_op_e'(op_i);
                cnt_q   <= CW'(ITER - 1);
                rem_q   <= '0;
                quo_q   <= a_abs;
                div_q   <= b_abs;
                neg_q_q <= a_neg ^ b_neg;
                neg_r_q <= a_neg;
                if (special) result_q <= special_res;
            end else if (state_q == BUSY && !flush_i) begin
                cnt_q <= cnt_q - CW'(1);
                rem_q <= step_rem;
                quo_q <= step_quo;
                if (cnt_q == '0) result_q <= final_res;
            end
        end
    end

    assign result_valid_o = valid_q;
    assign result_o       = result_q;

    // the divide instruction is frozen in ID/EX, so it cannot vanish mid-iteration
    a_start_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == BUSY && !flush_i) |-> start_i);
endmodule
